// File: rtl/decim2_D4_pkg.sv
// Shared types for the boxcar decimator: FSM state encoding and accumulator sizing.
package decim2_D4_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } state_t;

    // The accumulator needs D_LOG2 guard bits so that a full group of samples cannot overflow.
    function automatic int acc_width(input int data_w, input int d_log2);
        return data_w + d_log2;
    endfunction

endpackage

// File: rtl/decim2_D4_acc.sv
// Group accumulator: sign-extends and sums 2^D_LOG2 samples, then presents the floor average.
// It has no flow control of its own. The sample is captured on cap, one cycle after the FIFO pop.
module decim2_D4_acc
    import decim2_D4_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int D_LOG2 = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              clr,
    input  logic              cap,
    input  logic              byp,
    input  logic [DATA_W-1:0] rd_data,
    output logic              grp_last,
    output logic [DATA_W-1:0] wr_data
);

    localparam int ACC_W = acc_width(DATA_W, D_LOG2);

    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic        [D_LOG2-1:0] in_cnt_q, in_cnt_d;
    logic signed [ACC_W-1:0]  rd_sext;

    assign rd_sext  = {{D_LOG2{rd_data[DATA_W-1]}}, rd_data};
    assign grp_last = byp || (&in_cnt_q);

    // The upper DATA_W bits of acc are the arithmetic right shift by D_LOG2, so the result rounds toward -inf.
    assign wr_data = byp ? acc_q[DATA_W-1:0] : acc_q[ACC_W-1:D_LOG2];

    always_comb begin
        acc_d    = acc_q;
        in_cnt_d = in_cnt_q;
        if (clr) begin
            acc_d    = '0;
            in_cnt_d = '0;
        end else if (cap) begin
            acc_d    = (in_cnt_q == '0) ? rd_sext : acc_q + rd_sext;
            in_cnt_d = grp_last ? '0 : in_cnt_q + D_LOG2'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_q    <= '0;
            in_cnt_q <= '0;
        end else begin
            acc_q    <= acc_d;
            in_cnt_q <= in_cnt_d;
        end
    end

endmodule

// File: rtl/decim2_d4_fsm.sv
// FIFO-to-FIFO boxcar decimator by 2^D_LOG2. Each input costs 2 cycles and each output 1 cycle, with 2 cycles from the last pop to the push.
// It stalls in RD while Empty is high and in WR while Afull is high. Accel mode runs len outputs; stream mode runs until abort.
module decim2_d4_fsm
    import decim2_D4_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int D_LOG2 = 2,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              abort,
    input  logic              mode,
    input  logic              bypass,
    input  logic [LEN_W-1:0]  len,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              Empty,
    input  logic              Afull,
    output logic              Read_Enable,
    output logic              Write_Enable,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              stop_empty,
    output logic              stop_Afull
);

    state_t             state_q, state_d;
    logic               mode_q, mode_d;
    logic               byp_q, byp_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   out_cnt_q, out_cnt_d;
    logic               acc_clr, acc_cap, grp_last;

    decim2_D4_acc #(
        .DATA_W (DATA_W),
        .D_LOG2 (D_LOG2)
    ) u_acc (
        .clk      (clk),
        .rstn     (rstn),
        .clr      (acc_clr),
        .cap      (acc_cap),
        .byp      (byp_q),
        .rd_data  (rd_data),
        .grp_last (grp_last),
        .wr_data  (wr_data)
    );

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        byp_d        = byp_q;
        len_d        = len_q;
        out_cnt_d    = out_cnt_q;
        acc_clr      = 1'b0;
        acc_cap      = 1'b0;
        Read_Enable  = 1'b0;
        Write_Enable = 1'b0;
        stop_empty   = 1'b0;
        stop_Afull   = 1'b0;
        done         = 1'b0;
        busy         = (state_q != IDLE);

        // abort and start override every state action, so a pending pop, capture or push is dropped.
        if (abort) begin
            state_d = IDLE;
        end else if (start) begin
            mode_d    = mode;
            byp_d     = bypass;
            len_d     = len;
            out_cnt_d = '0;
            acc_clr   = 1'b1;
            state_d   = (!mode && len == '0) ? DONE : RD;
        end else begin
            case (state_q)
                RD: begin
                    if (Empty) begin
                        stop_empty = 1'b1;
                    end else begin
                        Read_Enable = 1'b1;
                        state_d     = CAP;
                    end
                end
                CAP: begin
                    acc_cap = 1'b1;
                    state_d = grp_last ? WR : RD;
                end
                WR: begin
                    if (Afull) begin
                        stop_Afull = 1'b1;
                    end else begin
                        Write_Enable = 1'b1;
                        out_cnt_d    = out_cnt_q + LEN_W'(1);
                        state_d      = (!mode_q && out_cnt_q == len_q - LEN_W'(1)) ? DONE : RD;
                    end
                end
                DONE: begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            mode_q    <= 1'b0;
            byp_q     <= 1'b0;
            len_q     <= '0;
            out_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            byp_q     <= byp_d;
            len_q     <= len_d;
            out_cnt_q <= out_cnt_d;
        end
    end

endmodule
